// File: rtl/rx_buf_writer_pkg.sv
// Shared types and sizing for the receive-buffer writer and its status queue.
package rx_buf_writer_pkg;

    localparam int NUM_SLOTS = 2;
    localparam int BUF_AW    = 11;
    localparam int SLOT_AW   = 10;
    localparam int LEN_W     = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic             slot;
        logic [LEN_W-1:0] len;
    } stat_entry_t;

endpackage

// File: rtl/rx_stat_fifo.sv
// Two-entry FIFO of completed-frame descriptors {slot, len}.
// A push while full is only taken if a pop happens in the same cycle.
module rx_stat_fifo
    import rx_buf_writer_pkg::*;
(
    input  logic           clk_int,
    input  logic           rst_int,
    input  logic           push,
    input  logic [LEN_W:0] push_data,
    input  logic           pop,
    output logic [LEN_W:0] head,
    output logic           empty,
    output logic           full
);

    stat_entry_t mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_buf_writer.sv
// Writes received frames into a two-slot 2048x16 buffer and queues completed
// frames for the consumer.
//
// state   | meaning
// IDLE    | waiting for the first byte of a frame
// RECV    | writing bytes of an accepted frame into the claimed slot
// DROP    | discarding the rest of a frame until its last byte
module rx_buf_writer
    import rx_buf_writer_pkg::*;
#(
    parameter int MAX_LEN = 1536,
    parameter int MIN_LEN = 60
) (
    input  logic              clk_int,
    input  logic              rst_int,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_last,
    input  logic              rx_err,
    output logic              buf_ena,
    output logic [1:0]        buf_wea,
    output logic [BUF_AW-1:0] buf_addra,
    output logic [15:0]       buf_dina,
    output logic              frm_avail,
    output logic              frm_slot,
    output logic [LEN_W-1:0]  frm_len,
    input  logic              frm_ack,
    output logic [15:0]       drop_cnt
);

    rx_state_t              state;
    logic                   cur_slot;
    logic [11:0]            byte_cnt;
    logic [NUM_SLOTS-1:0]   slot_busy;
    logic [NUM_SLOTS-1:0]   slot_set;
    logic [NUM_SLOTS-1:0]   slot_clr;

    logic                   in_idle;
    logic                   in_recv;
    logic                   free_avail;
    logic                   free_slot;
    logic                   over;
    logic                   wr_en;
    logic                   wr_slot;
    logic [10:0]            wr_idx;
    logic [11:0]            close_len;
    logic                   close_bad;
    logic                   push;
    logic                   pop;
    logic                   drop_inc;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [LEN_W:0]         head_raw;
    stat_entry_t            head;
    stat_entry_t            push_entry;

    assign in_idle    = (state == ST_IDLE);
    assign in_recv    = (state == ST_RECV);
    assign free_avail = ~(slot_busy[0] & slot_busy[1]);
    assign free_slot  = slot_busy[0];

    // A beat arriving when the frame already holds MAX_LEN bytes overflows.
    assign over      = rx_valid && in_recv && (byte_cnt == 12'(MAX_LEN));
    assign wr_en     = rx_valid && ((in_idle && free_avail) || (in_recv && !over));
    assign wr_slot   = in_idle ? free_slot : cur_slot;
    assign wr_idx    = in_idle ? 11'd0 : byte_cnt[10:0];
    assign close_len = in_idle ? 12'd1 : byte_cnt + 12'd1;
    assign close_bad = wr_en && rx_last && (rx_err || (close_len < 12'(MIN_LEN)));
    assign push      = wr_en && rx_last && !close_bad;
    assign pop       = frm_ack && !fifo_empty;
    assign drop_inc  = (rx_valid && in_idle && !free_avail) || over || close_bad;

    assign push_entry = '{slot: wr_slot, len: close_len[LEN_W-1:0]};
    assign head       = head_raw;
    assign frm_avail  = !fifo_empty;
    assign frm_slot   = head.slot;
    assign frm_len    = head.len;

    // Slot claim/release events for this cycle; a freed slot becomes claimable next cycle.
    always_comb begin
        slot_set = '0;
        slot_clr = '0;
        if (rx_valid && in_idle && free_avail) slot_set[free_slot] = 1'b1;
        if (close_bad)                          slot_clr[wr_slot]   = 1'b1;
        if (over)                               slot_clr[cur_slot]  = 1'b1;
        if (pop)                                slot_clr[head.slot] = 1'b1;
    end

    rx_stat_fifo u_stat_fifo (
        .clk_int   (clk_int),
        .rst_int   (rst_int),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Frame FSM, slot ownership, drop counter and registered buffer write port.
    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            state     <= ST_IDLE;
            cur_slot  <= 1'b0;
            byte_cnt  <= '0;
            slot_busy <= '0;
            drop_cnt  <= '0;
            buf_ena   <= 1'b0;
            buf_wea   <= 2'b00;
            buf_addra <= '0;
            buf_dina  <= '0;
        end else begin
            buf_ena   <= 1'b0;
            buf_wea   <= 2'b00;
            slot_busy <= (slot_busy | slot_set) & ~slot_clr;

            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (wr_en) begin
                buf_ena   <= 1'b1;
                buf_wea   <= wr_idx[0] ? 2'b10 : 2'b01;
                buf_addra <= {wr_slot, wr_idx[10:1]};
                buf_dina  <= {rx_data, rx_data};
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (free_avail) begin
                            cur_slot <= free_slot;
                            byte_cnt <= 12'd1;
                            state    <= rx_last ? ST_IDLE : ST_RECV;
                        end else begin
                            state    <= rx_last ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        if (over) begin
                            state <= rx_last ? ST_IDLE : ST_DROP;
                        end else begin
                            byte_cnt <= byte_cnt + 12'd1;
                            if (rx_last) state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (rx_valid && rx_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_buf_writer.sv
// Scoreboard bench: stimulus queues expected buffer writes and frame
// descriptors; monitors compare them when the DUT writes or a frame is acked.
module tb_rx_buf_writer;

    localparam int MAX_LEN = 1536;
    localparam int MIN_LEN = 60;

    logic        clk_int = 1'b0;
    logic        rst_int;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        rx_err;
    logic        buf_ena;
    logic [1:0]  buf_wea;
    logic [10:0] buf_addra;
    logic [15:0] buf_dina;
    logic        frm_avail;
    logic        frm_slot;
    logic [10:0] frm_len;
    logic        frm_ack;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_drop = 0;

    logic [28:0] wq [$];
    logic [11:0] sq [$];
    logic [28:0] w_exp;
    logic [11:0] s_exp;

    rx_buf_writer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk_int   (clk_int),
        .rst_int   (rst_int),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_last   (rx_last),
        .rx_err    (rx_err),
        .buf_ena   (buf_ena),
        .buf_wea   (buf_wea),
        .buf_addra (buf_addra),
        .buf_dina  (buf_dina),
        .frm_avail (frm_avail),
        .frm_slot  (frm_slot),
        .frm_len   (frm_len),
        .frm_ack   (frm_ack),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_int = ~clk_int;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write monitor: every buffer write must match the next expected write.
    always @(negedge clk_int) begin
        if (buf_ena) begin
            if (wq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr=%0h wea=%0b din=%0h expected no write",
                         buf_addra, buf_wea, buf_dina);
            end else begin
                w_exp = wq.pop_front();
                chk("write", {3'b0, buf_addra, buf_wea, buf_dina}, {3'b0, w_exp});
            end
        end else if (buf_wea != 2'b00) begin
            n_checks++;
            $display("FAIL wea_idle: got %0b expected 0", buf_wea);
        end
    end

    // Status monitor: on each accepted ack the head must match the next expected frame.
    always @(negedge clk_int) begin
        if (frm_ack && frm_avail) begin
            if (sq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: got slot=%0d len=%0d expected none", frm_slot, frm_len);
            end else begin
                s_exp = sq.pop_front();
                chk("frame_head", {20'b0, frm_slot, frm_len}, {20'b0, s_exp});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_int);
        #1;
    endtask

    task automatic ack();
        frm_ack = 1'b1;
        @(posedge clk_int); #1;
        frm_ack = 1'b0;
    endtask

    // slot < 0 means no writes are expected; nwr bytes are expected to be written.
    task automatic send_frame(input int len, input bit err, input int slot, input int nwr,
                              input bit fin, input bit ack_last);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d        = 8'(i * 3 + len);
            rx_valid = 1'b1;
            rx_data  = d;
            rx_last  = fin && (i == len - 1);
            rx_err   = err && fin && (i == len - 1);
            frm_ack  = ack_last && (i == len - 1);
            if (slot >= 0 && i < nwr)
                wq.push_back({1'(slot), 10'(i >> 1), (i % 2 == 1) ? 2'b10 : 2'b01, d, d});
            @(posedge clk_int); #1;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        frm_ack  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_int  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        frm_ack  = 1'b0;
        repeat (3) @(posedge clk_int);
        @(negedge clk_int);
        chk("rst_avail", 32'(frm_avail), 0);
        chk("rst_ena",   32'(buf_ena),   0);
        chk("rst_wea",   32'(buf_wea),   0);
        chk("rst_addr",  32'(buf_addra), 0);
        chk("rst_din",   32'(buf_dina),  0);
        chk("rst_slot",  32'(frm_slot),  0);
        chk("rst_len",   32'(frm_len),   0);
        chk("rst_drop",  32'(drop_cnt),  0);
        @(posedge clk_int); #1;
        rst_int = 1'b0;
        idle(1);

        // 64-byte good frame into slot 0
        sq.push_back({1'b0, 11'd64});
        send_frame(64, 0, 0, 64, 1, 0);
        idle(2);
        chk("t1_avail", 32'(frm_avail), 1);
        chk("t1_slot",  32'(frm_slot),  0);
        chk("t1_len",   32'(frm_len),   64);
        ack();
        chk("t1_avail_after_ack", 32'(frm_avail), 0);

        // two queued frames fill both slots; third is dropped without writes
        sq.push_back({1'b0, 11'd100});
        send_frame(100, 0, 0, 100, 1, 0);
        idle(1);
        sq.push_back({1'b1, 11'd70});
        send_frame(70, 0, 1, 70, 1, 0);
        idle(1);
        chk("t2_head_slot", 32'(frm_slot), 0);
        chk("t2_head_len",  32'(frm_len),  100);
        send_frame(80, 0, -1, 0, 1, 0);
        exp_drop++;
        idle(1);
        chk("t2_drop",  32'(drop_cnt),  32'(exp_drop));
        chk("t2_avail", 32'(frm_avail), 1);
        // slot 0 freed by ack is claimed by a frame starting the next cycle
        ack();
        sq.push_back({1'b0, 11'd64});
        send_frame(64, 0, 0, 64, 1, 0);
        idle(1);
        ack();
        ack();
        chk("t2_avail_empty", 32'(frm_avail), 0);

        // errored frame is discarded, slot 0 reused; MIN_LEN boundary
        send_frame(100, 1, 0, 100, 1, 0);
        exp_drop++;
        idle(1);
        chk("t3_err_avail", 32'(frm_avail), 0);
        chk("t3_err_drop",  32'(drop_cnt),  32'(exp_drop));
        sq.push_back({1'b0, 11'd60});
        send_frame(60, 0, 0, 60, 1, 0);
        idle(1);
        chk("t3_min_avail", 32'(frm_avail), 1);
        ack();
        send_frame(59, 0, 0, 59, 1, 0);
        exp_drop++;
        send_frame(1, 0, 0, 1, 1, 0);
        exp_drop++;
        idle(1);
        chk("t3_short_drop",  32'(drop_cnt),  32'(exp_drop));
        chk("t3_short_avail", 32'(frm_avail), 0);

        // MAX_LEN boundary: 1537 bytes overflow, 1536 bytes accepted
        send_frame(1537, 0, 0, 1536, 1, 0);
        exp_drop++;
        idle(1);
        chk("t4_over_drop",  32'(drop_cnt),  32'(exp_drop));
        chk("t4_over_avail", 32'(frm_avail), 0);
        sq.push_back({1'b0, 11'd1536});
        send_frame(1536, 0, 0, 1536, 1, 0);
        idle(1);
        chk("t4_max_len", 32'(frm_len), 1536);
        ack();

        // ack coinciding with the last byte of a second frame
        sq.push_back({1'b0, 11'd64});
        send_frame(64, 0, 0, 64, 1, 0);
        idle(1);
        sq.push_back({1'b1, 11'd80});
        send_frame(80, 0, 1, 80, 1, 1);
        idle(1);
        chk("t5_avail", 32'(frm_avail), 1);
        chk("t5_slot",  32'(frm_slot),  1);
        chk("t5_len",   32'(frm_len),   80);
        ack();
        chk("t5_empty", 32'(frm_avail), 0);

        // reset in the middle of a frame abandons it silently
        send_frame(30, 0, 0, 30, 0, 0);
        rst_int = 1'b1;
        idle(2);
        rst_int = 1'b0;
        exp_drop = 0;
        idle(1);
        chk("t6_avail", 32'(frm_avail), 0);
        chk("t6_drop",  32'(drop_cnt),  32'(exp_drop));
        sq.push_back({1'b0, 11'd60});
        send_frame(60, 0, 0, 60, 1, 0);
        idle(1);
        chk("t6_new_avail", 32'(frm_avail), 1);
        chk("t6_new_slot",  32'(frm_slot),  0);
        ack();

        idle(3);
        chk("writes_drained", 32'(wq.size()), 0);
        chk("frames_drained", 32'(sq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
